serial_add_sub: RTL



---
 rtl/arith_pkg.sv | 18 +
 rtl/digit_adder.sv | 28 ++
 rtl/serial_add_sub.sv | 100 ++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks:
// FSM state encoding, operation mode constants and a parameter legality check.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic bit digit_fits(input int unsigned width, input int unsigned digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into the
// slice's top bit so the caller can derive signed overflow.
module digit_adder #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             cm
);

    logic [DIGIT:0] cc;

    always_comb begin
        cc    = '0;
        s     = '0;
        cc[0] = ci;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            s[i]    = x[i] ^ y[i] ^ cc[i];
            cc[i+1] = (x[i] & y[i]) | (cc[i] & (x[i] ^ y[i]));
        end
        co = cc[DIGIT];
        cm = cc[DIGIT-1];
    end

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per
// clock, LSB first, with start/done handshake, carry-out and signed overflow.
module serial_add_sub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(STEPS - 1);

    if (!digit_fits(WIDTH, DIGIT)) begin : g_bad_digit
        $error("serial_add_sub: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, sr, sr_nx;
    logic             c;
    logic [KW-1:0]    k;
    logic [DIGIT-1:0] ds;
    logic             dco, dcm;
    logic             accept, last;

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .x  (sa[DIGIT-1:0]),
        .y  (sb[DIGIT-1:0]),
        .ci (c),
        .s  (ds),
        .co (dco),
        .cm (dcm)
    );

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_comb begin
        accept   = start && ready;
        last     = (k == KLAST);
        // new digit enters at the top; after STEPS shifts the first digit sits at bit 0
        sr_nx    = (sr >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last)   state_nx = DONE;
            DONE:    state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            c     <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sa <= a;
                sb <= b ^ {WIDTH{sub}};
                c  <= (sub == MODE_SUB) ? 1'b1 : cin;
                k  <= '0;
            end else if (state == RUN) begin
                sa <= sa >> DIGIT;
                sb <= sb >> DIGIT;
                sr <= sr_nx;
                c  <= dco;
                k  <= k + 1'b1;
                if (last) begin
                    sum  <= sr_nx;
                    cout <= dco;
                    ovf  <= dcm ^ dco;
                end
            end
        end
    end

endmodule
